// File: rtl/imem_prog.sv
// Instruction memory with a byte-serial program loader.
// A little-endian length word precedes the program words; fetches return NOP_WORD while loading.
module imem_prog #(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] NOP_WORD   = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  output logic [31:0] rd_data,
  input  logic        ld_start,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  output logic        ld_ready,
  output logic        ld_busy,
  output logic        ld_done,
  output logic        ld_err
);

  localparam int          DEPTH   = 2 ** ADDR_WIDTH;
  localparam logic [32:0] DEPTH_W = 33'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_DONE, S_ERR} state_t;

  state_t                state_q, state_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [23:0]           shift_q, shift_d;
  logic [31:0]           len_q, len_d;
  logic [31:0]           word_cnt_q, word_cnt_d;
  logic [ADDR_WIDTH:0]   wptr_q, wptr_d;
  logic [31:0]           rd_data_q;
  logic [31:0]           mem [DEPTH];

  logic                  accept;
  logic                  mem_we;
  logic [31:0]           asm_word;
  logic                  out_of_range;
  logic [ADDR_WIDTH-1:0] fetch_idx;
  logic                  addr_unused;

  // The incoming byte completes the word on the fourth byte of a group.
  assign asm_word     = {ld_data, shift_q};
  assign out_of_range = (addr[31:ADDR_WIDTH+2] != '0);
  assign fetch_idx    = addr[ADDR_WIDTH+1:2];
  assign addr_unused  = ^addr[1:0];

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    wptr_d     = wptr_q;
    mem_we     = 1'b0;
    ld_ready   = (state_q == S_LEN) || (state_q == S_DATA);
    ld_busy    = ld_ready;
    ld_done    = (state_q == S_DONE);
    ld_err     = (state_q == S_ERR);
    accept     = ld_valid && ld_ready;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (ld_start) begin
          state_d    = S_LEN;
          byte_cnt_d = '0;
          shift_d    = '0;
          len_d      = '0;
          word_cnt_d = '0;
          wptr_d     = '0;
        end
      end
      S_LEN: begin
        if (accept) begin
          shift_d    = asm_word[31:8];
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            len_d      = asm_word;
            word_cnt_d = '0;
            wptr_d     = '0;
            if (asm_word == '0)                   state_d = S_DONE;
            else if ({1'b0, asm_word} > DEPTH_W)  state_d = S_ERR;
            else                                  state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          shift_d    = asm_word[31:8];
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            // Pointer MSB set would mean a wrap; the length check makes it unreachable.
            mem_we     = !wptr_q[ADDR_WIDTH];
            wptr_d     = wptr_q + 1'b1;
            word_cnt_d = word_cnt_q + 32'd1;
            if (word_cnt_q + 32'd1 == len_q) state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      len_q      <= '0;
      word_cnt_q <= '0;
      wptr_q     <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      wptr_q     <= wptr_d;
    end
  end

  // Memory array is deliberately left out of reset so a program survives rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wptr_q[ADDR_WIDTH-1:0]] <= asm_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      rd_data_q <= NOP_WORD;
    else if (out_of_range || ld_busy) rd_data_q <= NOP_WORD;
    else                             rd_data_q <= mem[fetch_idx];
  end

  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_imem_prog.sv
// Self-checking bench for imem_prog: a byte-count model of the loader checked every cycle,
// plus directed loads with literal expectations on a 16-word and a 4096-word instance.
module tb_imem_prog;

  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] a_addr, b_addr;
  logic        a_start, a_valid, b_start, b_valid;
  logic [7:0]  a_data, b_data;
  logic [31:0] a_rd_data, b_rd_data;
  logic        a_ready, a_busy, a_done, a_err;
  logic        b_ready, b_busy, b_done, b_err;

  imem_prog #(.ADDR_WIDTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .addr(a_addr), .rd_data(a_rd_data),
    .ld_start(a_start), .ld_valid(a_valid), .ld_data(a_data),
    .ld_ready(a_ready), .ld_busy(a_busy), .ld_done(a_done), .ld_err(a_err)
  );

  imem_prog #(.ADDR_WIDTH(12)) dut_b (
    .clk(clk), .rst_n(rst_n), .addr(b_addr), .rd_data(b_rd_data),
    .ld_start(b_start), .ld_valid(b_valid), .ld_data(b_data),
    .ld_ready(b_ready), .ld_busy(b_busy), .ld_done(b_done), .ld_err(b_err)
  );

  int tests = 0;
  int fails = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of instance A (16 words): loader status derived from bytes accepted since ld_start.
  bit          m_active = 0, m_done = 0, m_err = 0;
  int          m_cnt = 0;
  longint      m_len = 0;
  logic [31:0] m_word = '0;
  logic [31:0] m_mem [16];
  bit          m_known [16];
  logic [31:0] m_rd = NOP;
  bit          m_rd_known = 1;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_active = 0; m_done = 0; m_err = 0; m_cnt = 0; m_len = 0;
        m_rd = NOP; m_rd_known = 1;
      end else begin
        if (a_addr[31:6] != 0 || m_active) begin
          m_rd = NOP; m_rd_known = 1;
        end else begin
          m_rd = m_mem[a_addr[5:2]];
          m_rd_known = m_known[a_addr[5:2]];
        end
        if (a_start && !m_active) begin
          m_active = 1; m_done = 0; m_err = 0; m_cnt = 0; m_len = 0;
        end else if (m_active && a_valid) begin
          if (m_cnt < 4) begin
            m_len = m_len | (longint'(a_data) << (8 * m_cnt));
            if (m_cnt == 3) begin
              if (m_len == 0)     begin m_active = 0; m_done = 1; end
              else if (m_len > 16) begin m_active = 0; m_err = 1; end
            end
          end else begin
            int k, w;
            k = m_cnt - 4;
            w = k / 4;
            m_word[8*(k%4) +: 8] = a_data;
            if (k % 4 == 3) begin
              m_mem[w] = m_word;
              m_known[w] = 1;
              if (w == m_len - 1) begin m_active = 0; m_done = 1; end
            end
          end
          m_cnt++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_rd_known) check32("cyc_rd_data", a_rd_data, m_rd);
      check32("cyc_ready", {31'b0, a_ready}, {31'b0, m_active});
      check32("cyc_busy",  {31'b0, a_busy},  {31'b0, m_active});
      check32("cyc_done",  {31'b0, a_done},  {31'b0, m_done});
      check32("cyc_err",   {31'b0, a_err},   {31'b0, m_err});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int w, input logic s, input logic v, input logic [7:0] d);
    if (w == 0) begin a_start = s; a_valid = v; a_data = d; end
    else        begin b_start = s; b_valid = v; b_data = d; end
  endtask

  task automatic start_load(input int w);
    drive(w, 1'b1, 1'b0, 8'h00);
    tick();
    drive(w, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_word(input int w, input logic [31:0] word, input int maxgap);
    for (int i = 0; i < 4; i++) begin
      int gap;
      gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      repeat (gap) begin drive(w, 1'b0, 1'b0, 8'h00); tick(); end
      drive(w, 1'b0, 1'b1, word[8*i +: 8]);
      tick();
    end
    drive(w, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic fetch(input int w, input logic [31:0] ad, output logic [31:0] d);
    if (w == 0) a_addr = ad; else b_addr = ad;
    tick();
    d = (w == 0) ? a_rd_data : b_rd_data;
  endtask

  function automatic logic [31:0] word_of(input int i);
    return 32'hC0DE0000 + 32'(i) * 32'h00010001;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    rst_n = 1'b0;
    a_addr = '0; b_addr = '0;
    drive(0, 1'b0, 1'b0, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00);
    repeat (3) tick();
    check32("reset_rd_data", a_rd_data, NOP);
    rst_n = 1'b1;
    tick();

    // Two-word program on both instances.
    for (int w = 0; w < 2; w++) begin
      start_load(w);
      send_word(w, 32'd2, 0);
      send_word(w, 32'h000000b7, 0);
      send_word(w, 32'h00508093, 0);
      check32("load2_done", {31'b0, (w == 0) ? a_done : b_done}, 32'd1);
      fetch(w, 32'h0, d); check32("load2_word0", d, 32'h000000b7);
      fetch(w, 32'h4, d); check32("load2_word1", d, 32'h00508093);
      $display("[TB] inst %0d: load N=2 then fetch 0/4", w);
    end
    fetch(1, 32'h00004000, d); check32("oor_4000", d, NOP);
    fetch(0, 32'h00000040, d); check32("oor_40", d, NOP);
    $display("[TB] out-of-range fetches");

    // Asynchronous reset between clock edges.
    a_addr = '0; b_addr = '0;
    tick();
    check32("pre_reset_rd", a_rd_data, 32'h000000b7);
    #2 rst_n = 1'b0;
    #1;
    check32("async_rd_a", a_rd_data, NOP);
    check32("async_rd_b", b_rd_data, NOP);
    check32("async_flags", {28'b0, a_ready, a_busy, a_done, a_err}, 32'd0);
    check32("async_done_b", {31'b0, b_done}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    fetch(0, 32'h0, d); check32("retain_after_reset", d, 32'h000000b7);
    $display("[TB] mid-cycle reset and release");

    // Full-depth load with gaps, fetch held at 0, spurious ld_start mid-load.
    a_addr = '0;
    start_load(0);
    send_word(0, 32'd16, 2);
    for (int i = 0; i < 16; i++) begin
      send_word(0, word_of(i), 2);
      if (i == 5) begin
        check32("busy_rd_nop", a_rd_data, NOP);
        start_load(0);
        check32("midload_start_busy", {31'b0, a_busy}, 32'd1);
      end
    end
    check32("full_done", {31'b0, a_done}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      fetch(0, 32'(i * 4), d);
      check32("full_word", d, word_of(i));
    end
    $display("[TB] load N=16 with gaps");

    // Oversize length rejected, memory untouched.
    start_load(0);
    send_word(0, 32'd17, 1);
    check32("over_err",  {31'b0, a_err},  32'd1);
    check32("over_busy", {31'b0, a_busy}, 32'd0);
    check32("over_done", {31'b0, a_done}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      fetch(0, 32'(i * 4), d);
      check32("over_unchanged", d, word_of(i));
    end
    $display("[TB] load N=17 rejected");

    // ld_start with a valid byte in ERR: the byte must be dropped; then N=0 completes.
    drive(0, 1'b1, 1'b1, 8'hFF);
    tick();
    drive(0, 1'b0, 1'b0, 8'h00);
    send_word(0, 32'd0, 0);
    check32("zero_len_done", {31'b0, a_done}, 32'd1);
    check32("zero_len_err",  {31'b0, a_err},  32'd0);
    $display("[TB] start+byte in ERR, load N=0");

    // Reset after the first word of a three-word load.
    start_load(0);
    send_word(0, 32'd3, 0);
    send_word(0, 32'h12345678, 1);
    check32("partial_busy", {31'b0, a_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check32("partial_reset_busy", {31'b0, a_busy}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    fetch(0, 32'h0, d); check32("partial_word0", d, 32'h12345678);
    fetch(0, 32'h4, d); check32("partial_word1_old", d, word_of(1));
    $display("[TB] reset mid-load N=3");

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_prog.md
IMEM_PROG -- requirements
Module: imem_prog

Interface
REQ-001 SHALL provide parameter ADDR_WIDTH, default 12, word-address bits; DEPTH = 2**ADDR_WIDTH 32-bit words.
REQ-002 SHALL provide parameter NOP_WORD, default 32'h00000013, the word returned when no valid fetch data exists.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 addr  input  32  fetch byte address; addr[1:0] ignored.
REQ-007 rd_data  output  32  registered fetch data.
REQ-008 ld_start  input  1  single-cycle request to begin a program load.
REQ-009 ld_valid  input  1  ld_data byte valid.
REQ-010 ld_data  input  8  loader byte stream.
REQ-011 ld_ready  output  1  loader accepts a byte this cycle.
REQ-012 ld_busy  output  1  load in progress; core SHALL stall on this.
REQ-013 ld_done  output  1  last load completed successfully (level).
REQ-014 ld_err  output  1  last load rejected (level).

Function
REQ-015 Fetch: rd_data SHALL be mem[addr[ADDR_WIDTH+1:2]] registered one cycle after addr is presented (1-cycle latency, no combinational path).
REQ-016 Fetch SHALL return NOP_WORD when addr[31:ADDR_WIDTH+2] is nonzero or when ld_busy is 1.
REQ-017 Loader FSM states IDLE, LEN, DATA, DONE, ERR; reset state IDLE.
REQ-018 ld_start in IDLE, DONE or ERR SHALL move to LEN next cycle and clear ld_done/ld_err; ld_start in LEN or DATA SHALL be ignored.
REQ-019 A byte is accepted when ld_valid and ld_ready are both 1; ld_ready = 1 exactly in LEN and DATA; ld_valid gaps of any length SHALL be tolerated.
REQ-020 LEN: 4 accepted bytes, little-endian, form a 32-bit word count N.
REQ-021 After the 4th length byte: N = 0 -> DONE; N > DEPTH -> ERR with no memory writes; otherwise -> DATA with write pointer 0.
REQ-022 DATA: bytes assembled little-endian; on the 4th byte of each word the word SHALL be written at the write pointer in that same cycle, pointer then incremented.
REQ-023 After the Nth word write, FSM SHALL enter DONE the next cycle; N = DEPTH SHALL fill memory exactly without pointer wrap affecting any write.
REQ-024 ld_busy = 1 in LEN and DATA only; ld_done = 1 in DONE only; ld_err = 1 in ERR only; DONE/ERR held until next ld_start.
REQ-025 Byte-in-word counter 2 bits, word counter 32 bits, write pointer ADDR_WIDTH+1 bits; no truncation of N before the DEPTH comparison.
REQ-026 ld_start and an accepted byte in the same cycle in DONE/ERR: ld_start wins, byte discarded (ld_ready is 0 there).

Reset
REQ-027 rst_n low SHALL immediately force FSM IDLE, rd_data = NOP_WORD, ld_ready = ld_busy = ld_done = ld_err = 0, counters 0.
REQ-028 Memory contents SHALL NOT be reset; words written before a reset mid-load SHALL be retained.
REQ-029 Release of rst_n SHALL take effect on the first rising clk edge after deassertion with no spurious memory write.

Verification
REQ-030 Reset: assert rst_n=0 mid-cycle -> rd_data=0x00000013, ld_ready/ld_busy/ld_done/ld_err all 0 without a clock edge.
REQ-031 Load: ld_start, bytes 02 00 00 00 b7 00 00 00 93 80 50 00 -> ld_done=1; addr=0 -> rd_data=0x000000b7 next cycle; addr=4 -> 0x00508093.
REQ-032 Oversize (ADDR_WIDTH=4): length bytes 11 00 00 00 (N=17) -> ld_err=1, ld_busy=0, memory unchanged; N=16 load -> ld_done=1, all 16 words readable.
REQ-033 Fetch during load with random ld_valid gaps -> rd_data=0x00000013 while ld_busy=1; ld_start mid-load ignored.
REQ-034 Out of range (ADDR_WIDTH=12): addr=0x00004000 -> rd_data=0x00000013.
REQ-035 Reset mid-load after word 0 of N=3 written -> IDLE, ld_busy=0; fetch addr 0 returns word 0.
